procedural_rr_sequencer: RTL
============================

Name: procedural_rr_sequencer

Overview:
- Shares one procedural arithmetic datapath among NUM_REQ requesters.
- Each requester presents an operand pair and a select bit with a valid/ready handshake. A round-robin arbiter grants one requester at a time. The block captures its operands, computes in a registered execute stage, and returns results plus the requester ID on a valid/ready response port.
- Sits between multiple client blocks and a single shared arithmetic resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width.
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set (one-hot or zero).
- req_in1  input  NUM_REQ*WIDTH  packed operand 1; requester i uses bits [i*WIDTH +: WIDTH].
- req_in2  input  NUM_REQ*WIDTH  packed operand 2, same packing.
- req_sel  input  NUM_REQ  per-requester mode select.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_out1  output  WIDTH  result 1.
- rsp_out2  output  WIDTH  result 2.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset sets:
  - state=IDLE, rr pointer=0.
  - rsp_valid=0, rsp_id=0, rsp_out1=0, rsp_out2=0, captured operands=0.
  - req_ready=0, busy=0.
- IDLE:
  - Arbiter searches req_valid starting at rr pointer, ascending, wrapping NUM_REQ-1 -> 0.
  - First set bit g is the grant; req_ready[g]=1 combinationally in the same cycle.
  - Handshake completes when req_valid[g] && req_ready[g]. At that edge: capture in1/in2/sel of g, capture id=g, rr pointer <= (g+1) mod NUM_REQ, go to EXEC.
  - No valid: req_ready=0, pointer unchanged, stay IDLE.
- req_ready is 0 in EXEC and RESP. Requesters hold valid and data until accepted; a valid dropped before acceptance is simply not served.
- EXEC (exactly 1 cycle), all results mod 2**WIDTH, operands unsigned:
  - t1 = (in1+in2)*10.
  - sel=1: t2 = t1 ^ (in1 >> 2), logical shift; out1 = t2 & in2.
  - sel=0: t2 = t1 | (in2 << 3); out1 = t2 + in1.
  - out2 = t1 - t2, wrapping.
  - Results are registered into rsp_out1/rsp_out2/rsp_id; rsp_valid <= 1; next state RESP.
- RESP:
  - Outputs held stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid <= 0, go to IDLE. rsp_out*/rsp_id keep their last values.
- Latency: accept at edge N, rsp_valid high after edge N+1. Next accept is possible at the earliest 1 cycle after the response handshake, so peak throughput is one transaction per 3 cycles.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 other grants.
- Simultaneous valid on all requesters after reset: grant order 0,1,2,3,0,...
- Reset asserted in EXEC or RESP: the in-flight transaction is discarded and every state element returns to its reset value on that edge. No response is produced.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro PROC_SEQ_STATS_EN.
- Defined:
  - Adds output grant_count (16 bits): number of accepted requests.
  - Adds output stall_count (16 bits): cycles with rsp_valid && !rsp_ready.
  - Both counters are 0 at reset and wrap 0xFFFF -> 0.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then requester 0 sends in1=3, in2=5, sel=1, rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_id=0, out1=0x0000, out2=0x0000.
- Requester 2 sends in1=3, in2=5, sel=0 -> rsp_id=2, out1=0x007B, out2=0xFFD8.
- Requester 1 sends in1=0x0004, in2=0x0002, sel=1 -> out1=0x0000, out2=0xFFFF. Requester 3 sends in1=0xFFFF, in2=0x0001, sel=0 -> t1=0, out1=0x0007, out2=0xFFF8.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 in order; req_ready never multi-hot; each grant is 3 cycles apart.
- rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0; with PROC_SEQ_STATS_EN, stall_count=5 and grant_count=1.
- rst pulsed during EXEC with requester 1 accepted -> no rsp_valid. The next grant with all valid goes to requester 0, since the pointer is reset.

Source files
------------

// File: rtl/procedural_rr_sequencer.sv
// ----------------------------------------------------------------------------
// procedural_rr_sequencer
//
// Shares one registered arithmetic datapath among NUM_REQ requesters. A
// round-robin arbiter picks one valid requester while idle and captures its
// operand pair and mode bit. The block computes the result in a single EXEC
// cycle and presents it, tagged with the requester index, on a valid/ready
// response port. It then waits in RESP until the consumer accepts.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WIDTH    operand / result width
//   ID_W     requester index width, 2**ID_W >= NUM_REQ
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept, one-hot or zero, combinational in IDLE
//   req_in1    packed operand 1, requester i at [i*WIDTH +: WIDTH]
//   req_in2    packed operand 2, same packing
//   req_sel    per-requester mode select
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     index of the requester owning the response
//   rsp_out1   result 1
//   rsp_out2   result 2
//   busy       high whenever the FSM is not idle
//
// Optional feature (macro PROC_SEQ_STATS_EN):
//   grant_count  16-bit wrapping count of accepted requests
//   stall_count  16-bit wrapping count of cycles with rsp_valid && !rsp_ready
// ----------------------------------------------------------------------------
module procedural_rr_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
    input  logic [NUM_REQ-1:0]         req_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_out1,
    output logic [WIDTH-1:0]           rsp_out2,
`ifdef PROC_SEQ_STATS_EN
    output logic [15:0]                grant_count,
    output logic [15:0]                stall_count,
`endif
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] MUL_K = WIDTH'(10);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e            state_q,    state_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [WIDTH-1:0]  in1_q,      in1_d;
    logic [WIDTH-1:0]  in2_q,      in2_d;
    logic              sel_q,      sel_d;
    logic [ID_W-1:0]   cap_id_q,   cap_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q,   rsp_id_d;
    logic [WIDTH-1:0]  rsp_out1_q, rsp_out1_d;
    logic [WIDTH-1:0]  rsp_out2_q, rsp_out2_d;
`ifdef PROC_SEQ_STATS_EN
    logic [15:0]       grant_cnt_q, grant_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

    // ------------------------------------------------------------------------
    // Round-robin search: scan upward from rr_ptr_q, wrapping at NUM_REQ-1.
    // ------------------------------------------------------------------------
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   scan_id;
    int                scan_idx;

    // NOTE: combinational blocks give every output a default first so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            scan_id = ID_W'(scan_idx);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // Ready is only offered in IDLE. It is held low during reset so that no
    // requester sees a handshake the register update is about to discard.
    logic accept;
    assign accept = (state_q == S_IDLE) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Execute-stage datapath, all arithmetic modulo 2**WIDTH.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] t1, t2, res1, res2;

    always_comb begin
        t1 = (in1_q + in2_q) * MUL_K;
        if (sel_q) begin
            t2   = t1 ^ (in1_q >> 2);
            res1 = t2 & in2_q;
        end else begin
            t2   = t1 | (in2_q << 3);
            res1 = t2 + in1_q;
        end
        res2 = t1 - t2;
    end

    // ------------------------------------------------------------------------
    // Next-state and register inputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        sel_d       = sel_q;
        cap_id_d    = cap_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_out1_d  = rsp_out1_q;
        rsp_out2_d  = rsp_out2_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    in1_d    = req_in1[int'(grant_id)*WIDTH +: WIDTH];
                    in2_d    = req_in2[int'(grant_id)*WIDTH +: WIDTH];
                    sel_d    = req_sel[grant_id];
                    cap_id_d = grant_id;
                    rr_ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_out1_d  = res1;
                rsp_out2_d  = res2;
                rsp_id_d    = cap_id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                // Results and id stay put after the handshake; only valid drops.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef PROC_SEQ_STATS_EN
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
        if (rsp_valid_q && !rsp_ready) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Registers. Every element, including captured operands, returns to zero
    // on reset so an aborted transaction leaves no trace.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            sel_q       <= 1'b0;
            cap_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out1_q  <= '0;
            rsp_out2_q  <= '0;
`ifdef PROC_SEQ_STATS_EN
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            sel_q       <= sel_d;
            cap_id_q    <= cap_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out1_q  <= rsp_out1_d;
            rsp_out2_q  <= rsp_out2_d;
`ifdef PROC_SEQ_STATS_EN
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out1  = rsp_out1_q;
    assign rsp_out2  = rsp_out2_q;
    assign busy      = (state_q != S_IDLE);
`ifdef PROC_SEQ_STATS_EN
    assign grant_count = grant_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
